ball_motion: RTL
================

# ball_motion

Per-ball kinematics stage that consumes the collision resolver's per-ball outputs (velocity override, collision flag, hole hit) and maintains the ball's fixed-point position and velocity. Once per frame it applies any collision velocity, friction decay and position integration. It drives the ball's top-left pixel position and current velocity back to the collision resolver and the ball drawer. One instance per ball (white, red).

## Interface
Parameters:
- INITIAL_X, 200, spawn top-left X (pixels)
- INITIAL_Y, 240, spawn top-left Y (pixels)
- MAX_X, 639, maximum top-left X (pixels)
- MAX_Y, 479, maximum top-left Y (pixels)
- FRICTION_PERIOD, 4, frames between friction decrements (≥1)
- FIXED_POINT_MULTIPLIER, 64, sub-pixel units per pixel (power of 2)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per video frame
- cueHit  in  1  one-cycle launch request
- cueVelX, cueVelY  in  signed 11  launch velocity (sub-pixels/frame)
- collisionOccurred  in  1  collision flag from the collision resolver
- collVelX, collVelY  in  signed 11  resolved velocity from the collision resolver
- holeHit  in  1  ball entered a hole
- respawn  in  1  one-cycle request to return a pocketed ball to spawn
- topLeftPosX, topLeftPosY  out  11  integer pixel position (posX/posY divided by FIXED_POINT_MULTIPLIER)
- velX, velY  out  signed 11  current velocity
- moving  out  1  state == MOVING
- inHole  out  1  state == POCKETED

## Operation
- Internal registers:
  - posX, posY: 18-bit unsigned sub-pixel positions.
  - velX, velY: signed 11-bit velocities.
  - frameCnt: frame counter, range 0..FRICTION_PERIOD-1.
  - collLatch: collision latch, with latched velocities latVelX and latVelY.
- FSM states:
  - STOPPED: cueHit with a nonzero cueVelX or cueVelY loads velX/velY from the cue velocity, sets frameCnt to 0 and moves to MOVING. cueHit with both cue velocity components zero is ignored.
  - MOVING: cueHit is ignored. Per-frame update runs on each startOfFrame (see below).
  - POCKETED: velX/velY are 0 and position is frozen. All inputs are ignored except respawn. respawn sets position to INITIAL_X/INITIAL_Y times FIXED_POINT_MULTIPLIER, clears collLatch, and moves to STOPPED.
- holeHit in STOPPED or MOVING moves to POCKETED, zeroes velX/velY and clears collLatch. holeHit has priority over every other event in the same cycle.
- Collision latch:
  - In MOVING or STOPPED, the first cycle with collisionOccurred=1 and collLatch=0 sets collLatch and captures latVelX/latVelY.
  - Further assertions are ignored until the latch is consumed.
  - A collision captured in STOPPED moves the FSM to MOVING at the next startOfFrame, provided the latched velocity is nonzero.
- Per-frame update, on startOfFrame in MOVING (or in STOPPED with collLatch set):
  1. New velocity:
     - If collLatch is set: nv = latVel; clear collLatch.
     - Else if frameCnt == FRICTION_PERIOD-1: each component moves one unit toward zero (0 stays 0).
     - Else: nv = current velocity.
  2. frameCnt increments, wrapping to 0 after FRICTION_PERIOD-1.
  3. Position: pos = pos + sign_extend(nv), computed in 19-bit signed arithmetic.
     - A negative result saturates to 0.
     - A result above MAX*FIXED_POINT_MULTIPLIER saturates to that value.
  4. If both nv components are 0, go to STOPPED.
- collisionOccurred and startOfFrame in the same cycle: the collision is captured and applied in that same update; collVel is used directly.

## Timing
- Reset, asynchronous: state STOPPED, posX = INITIAL_X*FIXED_POINT_MULTIPLIER, posY = INITIAL_Y*FIXED_POINT_MULTIPLIER, velX/velY = 0, frameCnt = 0, collLatch = 0.
  - Outputs after reset: topLeftPosX = INITIAL_X, topLeftPosY = INITIAL_Y, velX/velY = 0, moving = 0, inHole = 0.
- All outputs are registered.
- Per-frame update latencies:
  - Velocity and position update: visible the cycle after startOfFrame.
  - cueHit to moving=1: 1 cycle.
  - holeHit to inHole=1: 1 cycle.
  - respawn to inHole=0 and spawn position: 1 cycle.
- Position and velocity change only on startOfFrame, cueHit (velocity only), holeHit (velocity only) or respawn.
- Deasserting resetN mid-frame discards collLatch and any in-progress motion.

## Test plan
- Cue launch: reset, then cueHit with cueVelX=128, cueVelY=0, then one startOfFrame -> moving=1, topLeftPosX=202, topLeftPosY=240, velX=128; after the 4th frame velX=127.
- Friction stop: cueHit with cueVelX=1, then 4 frames -> topLeftPosX stays 200 (sub-pixel posX=12803), velX=0, moving=0 after the 4th startOfFrame.
- Collision latch: while MOVING with velX=128, pulse collisionOccurred twice in one frame (collVelX=-64, then +300) -> next frame velX=-64 and posX decreases by 64 sub-pixels; the second pulse is ignored.
- Saturation: spawn at INITIAL_X=0, cueHit with cueVelX=-640 -> topLeftPosX=0 on every frame. Spawn at INITIAL_X=639, cueHit with cueVelX=+640 -> topLeftPosX=639 on every frame.
- Pocket/respawn: holeHit in the same cycle as collisionOccurred and startOfFrame -> inHole=1, velX/velY=0, position frozen for 3 frames; cueHit ignored; respawn -> topLeftPosX=200, topLeftPosY=240, inHole=0, moving=0.
- Reset mid-motion: assert resetN=0 while MOVING with a collision latched -> outputs return to reset values immediately; the first frame after release produces no movement.

Source files
------------

// File: rtl/ball_motion.sv
// Per-ball kinematics: cue launch, latched collision velocity, frame-based friction
// and saturating fixed-point position integration. One instance per ball.
module ball_motion #(
  parameter int INITIAL_X              = 200,
  parameter int INITIAL_Y              = 240,
  parameter int MAX_X                  = 639,
  parameter int MAX_Y                  = 479,
  parameter int FRICTION_PERIOD        = 4,
  parameter int FIXED_POINT_MULTIPLIER = 64
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               cueHit,
  input  logic signed [10:0] cueVelX,
  input  logic signed [10:0] cueVelY,
  input  logic               collisionOccurred,
  input  logic signed [10:0] collVelX,
  input  logic signed [10:0] collVelY,
  input  logic               holeHit,
  input  logic               respawn,
  output logic [10:0]        topLeftPosX,
  output logic [10:0]        topLeftPosY,
  output logic signed [10:0] velX,
  output logic signed [10:0] velY,
  output logic               moving,
  output logic               inHole
);

  // state     | meaning
  // STOPPED   | at rest, waiting for a cue hit or a collision
  // MOVING    | integrating position on every startOfFrame
  // POCKETED  | in a hole, frozen until respawn
  localparam logic [1:0] ST_STOPPED  = 2'd0;
  localparam logic [1:0] ST_MOVING   = 2'd1;
  localparam logic [1:0] ST_POCKETED = 2'd2;

  localparam int SHIFT = $clog2(FIXED_POINT_MULTIPLIER);
  localparam int CW    = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;

  localparam logic [17:0]   SPAWN_X  = 18'(INITIAL_X * FIXED_POINT_MULTIPLIER);
  localparam logic [17:0]   SPAWN_Y  = 18'(INITIAL_Y * FIXED_POINT_MULTIPLIER);
  localparam logic [18:0]   LIMIT_X  = 19'(MAX_X * FIXED_POINT_MULTIPLIER);
  localparam logic [18:0]   LIMIT_Y  = 19'(MAX_Y * FIXED_POINT_MULTIPLIER);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRICTION_PERIOD - 1);

  logic [1:0]          state;
  logic [17:0]         pos_x, pos_y;
  logic signed [10:0]  vel_x, vel_y;
  logic [CW-1:0]       frame_cnt;
  logic                coll_latch;
  logic signed [10:0]  lat_vx, lat_vy;

  logic                coll_take, apply_coll, update_en, cue_go;
  logic signed [10:0]  nv_x, nv_y;
  logic [CW-1:0]       cnt_next;

  function automatic logic signed [10:0] toward_zero(input logic signed [10:0] v);
    if (v > 0)      return v - 11'sd1;
    else if (v < 0) return v + 11'sd1;
    else            return v;
  endfunction

  function automatic logic [17:0] step_pos(input logic [17:0] p,
                                           input logic signed [10:0] v,
                                           input logic [18:0] limit);
    logic signed [18:0] sum;
    sum = $signed({1'b0, p}) + $signed({{8{v[10]}}, v});
    if (sum < 0)                    return 18'd0;
    else if (sum > $signed(limit))  return limit[17:0];
    else                            return sum[17:0];
  endfunction

  // A collision arriving with startOfFrame is applied in that same update.
  assign coll_take  = collisionOccurred & ~coll_latch;
  assign apply_coll = coll_latch | collisionOccurred;
  assign update_en  = startOfFrame &
                      ((state == ST_MOVING) | ((state == ST_STOPPED) & apply_coll));
  assign cue_go     = cueHit & (state == ST_STOPPED) &
                      ((cueVelX != 11'sd0) | (cueVelY != 11'sd0));
  assign cnt_next   = (frame_cnt == CNT_LAST) ? '0 : frame_cnt + CW'(1);

  always_comb begin
    nv_x = vel_x;
    nv_y = vel_y;
    if (coll_latch) begin
      nv_x = lat_vx;
      nv_y = lat_vy;
    end else if (collisionOccurred) begin
      nv_x = collVelX;
      nv_y = collVelY;
    end else if (frame_cnt == CNT_LAST) begin
      nv_x = toward_zero(vel_x);
      nv_y = toward_zero(vel_y);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= ST_STOPPED;
      pos_x      <= SPAWN_X;
      pos_y      <= SPAWN_Y;
      vel_x      <= '0;
      vel_y      <= '0;
      frame_cnt  <= '0;
      coll_latch <= 1'b0;
      lat_vx     <= '0;
      lat_vy     <= '0;
    end else begin
      case (state)
        ST_POCKETED: begin
          if (respawn) begin
            pos_x      <= SPAWN_X;
            pos_y      <= SPAWN_Y;
            frame_cnt  <= '0;
            coll_latch <= 1'b0;
            state      <= ST_STOPPED;
          end
        end
        ST_STOPPED, ST_MOVING: begin
          if (holeHit) begin
            vel_x      <= '0;
            vel_y      <= '0;
            coll_latch <= 1'b0;
            state      <= ST_POCKETED;
          end else if (cue_go) begin
            vel_x     <= cueVelX;
            vel_y     <= cueVelY;
            frame_cnt <= '0;
            state     <= ST_MOVING;
            if (coll_take) begin
              coll_latch <= 1'b1;
              lat_vx     <= collVelX;
              lat_vy     <= collVelY;
            end
          end else if (update_en) begin
            vel_x      <= nv_x;
            vel_y      <= nv_y;
            frame_cnt  <= cnt_next;
            pos_x      <= step_pos(pos_x, nv_x, LIMIT_X);
            pos_y      <= step_pos(pos_y, nv_y, LIMIT_Y);
            coll_latch <= 1'b0;
            state      <= ((nv_x == 11'sd0) && (nv_y == 11'sd0)) ? ST_STOPPED : ST_MOVING;
          end else if (coll_take) begin
            coll_latch <= 1'b1;
            lat_vx     <= collVelX;
            lat_vy     <= collVelY;
          end
        end
        default: state <= ST_STOPPED;
      endcase
    end
  end

  assign topLeftPosX = 11'(pos_x >> SHIFT);
  assign topLeftPosY = 11'(pos_y >> SHIFT);
  assign velX        = vel_x;
  assign velY        = vel_y;
  assign moving      = (state == ST_MOVING);
  assign inHole      = (state == ST_POCKETED);

endmodule
